// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared types for the seven-segment display arbiter.
//   state_t  : arbiter FSM states (idle, A owns display, B owns display)
//   req_id_t : requester identity, used to remember who was served last
//   digit_t  : one 4-bit digit code for the segment7 driver
//   word_t   : one 16-bit requester value (four digits, D1 in [3:0])
// -----------------------------------------------------------------------------
package seg7_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHOW_A = 2'd1,
        ST_SHOW_B = 2'd2
    } state_t;

    typedef enum logic {
        RID_A = 1'b0,
        RID_B = 1'b1
    } req_id_t;

    typedef logic [3:0]  digit_t;
    typedef logic [15:0] word_t;

endpackage

// File: rtl/seg7_dwell_timer.sv
// -----------------------------------------------------------------------------
// seg7_dwell_timer
// Saturating dwell counter. Counts cycles the current holder has owned the
// display and flags when the minimum dwell has been served.
// Parameters:
//   DWELL     : minimum hold time in cycles (>= 2)
// Ports:
//   clk_i     : system clock
//   rst_ni    : asynchronous active-low reset
//   clr_i     : synchronous clear to 0 (has priority over inc_i)
//   inc_i     : count up by one, saturating at DWELL-1
//   expired_o : count has reached DWELL-1
// -----------------------------------------------------------------------------
module seg7_dwell_timer #(
    parameter int DWELL = 40_000_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam int CW = $clog2(DWELL);
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != CNT_LAST)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == CNT_LAST);

endmodule

// File: rtl/seg7_arb.sv
// -----------------------------------------------------------------------------
// seg7_arb
// Two-requester round-robin arbiter in front of the segment7 driver. Grants
// the four-digit display to one requester at a time, holds it for at least
// DWELL cycles while the other is waiting, and streams the granted value
// into the digit registers every cycle.
// Parameters:
//   DWELL        : minimum hold cycles under contention (>= 2)
// Ports:
//   CLK          : system clock
//   IN_CLR       : asynchronous active-low reset
//   REQ_A/REQ_B  : level requests
//   DATA_A/DATA_B: 16-bit values, [3:0] -> D1 ... [15:12] -> D4
//   GNT_A/GNT_B  : current owner (mutually exclusive)
//   D1..D4       : digit codes
//   BUSY         : GNT_A | GNT_B
// Build option:
//   SEG7_ARB_IDLE_CLR_EN : when defined, digits clear to 0 on entry to idle;
//                          otherwise they retain the last granted value.
// -----------------------------------------------------------------------------
module seg7_arb
    import seg7_pkg::*;
#(
    parameter int DWELL = 40_000_000
) (
    input  logic        CLK,
    input  logic        IN_CLR,
    input  logic        REQ_A,
    input  logic [15:0] DATA_A,
    input  logic        REQ_B,
    input  logic [15:0] DATA_B,
    output logic        GNT_A,
    output logic        GNT_B,
    output logic [3:0]  D1,
    output logic [3:0]  D2,
    output logic [3:0]  D3,
    output logic [3:0]  D4,
    output logic        BUSY
);

    state_t  state_q, state_d;
    req_id_t last_q,  last_d;
    word_t   word_q,  word_d;
    logic    expired;
    logic    grant_change;

    // Next-state logic. A dropping holder always yields immediately; a holder
    // still requesting is only preempted once the dwell has been served.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (REQ_A && REQ_B) begin
                    state_d = (last_q == RID_B) ? ST_SHOW_A : ST_SHOW_B;
                end else if (REQ_A) begin
                    state_d = ST_SHOW_A;
                end else if (REQ_B) begin
                    state_d = ST_SHOW_B;
                end
            end
            ST_SHOW_A: begin
                if (!REQ_A) begin
                    state_d = REQ_B ? ST_SHOW_B : ST_IDLE;
                end else if (REQ_B && expired) begin
                    state_d = ST_SHOW_B;
                end
            end
            ST_SHOW_B: begin
                if (!REQ_B) begin
                    state_d = REQ_A ? ST_SHOW_A : ST_IDLE;
                end else if (REQ_A && expired) begin
                    state_d = ST_SHOW_A;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign grant_change = (state_d != state_q);

    // Data and "last served" follow the next state so that the digits change
    // on the same edge as the grant.
    always_comb begin
        last_d = last_q;
        word_d = word_q;
        unique case (state_d)
            ST_SHOW_A: begin
                word_d = DATA_A;
                if (grant_change) last_d = RID_A;
            end
            ST_SHOW_B: begin
                word_d = DATA_B;
                if (grant_change) last_d = RID_B;
            end
            default: begin
`ifdef SEG7_ARB_IDLE_CLR_EN
                if (grant_change) word_d = '0;
`else
                word_d = word_q;
`endif
            end
        endcase
    end

    always_ff @(posedge CLK or negedge IN_CLR) begin
        if (!IN_CLR) begin
            state_q <= ST_IDLE;
            last_q  <= RID_B;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            word_q  <= word_d;
        end
    end

    // Count only while someone holds the display; any grant change restarts it.
    seg7_dwell_timer #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk_i     (CLK),
        .rst_ni    (IN_CLR),
        .clr_i     (grant_change),
        .inc_i     (state_q != ST_IDLE),
        .expired_o (expired)
    );

    assign GNT_A = (state_q == ST_SHOW_A);
    assign GNT_B = (state_q == ST_SHOW_B);
    assign BUSY  = GNT_A | GNT_B;
    assign D1    = word_q[3:0];
    assign D2    = word_q[7:4];
    assign D3    = word_q[11:8];
    assign D4    = word_q[15:12];

endmodule

// File: tb/tb_seg7_arb.sv
`timescale 1ns/100ps
// -----------------------------------------------------------------------------
// tb_seg7_arb
// Directed bench for seg7_arb with DWELL=4. Inputs change 1 ns after a rising
// edge; outputs are sampled at the same point, i.e. they reflect that edge.
// -----------------------------------------------------------------------------
module tb_seg7_arb;

    logic        CLK = 1'b0;
    logic        IN_CLR;
    logic        REQ_A, REQ_B;
    logic [15:0] DATA_A, DATA_B;
    logic        GNT_A, GNT_B, BUSY;
    logic [3:0]  D1, D2, D3, D4;

    int checks = 0;
    int errors = 0;

    seg7_arb #(.DWELL(4)) dut (
        .CLK    (CLK),
        .IN_CLR (IN_CLR),
        .REQ_A  (REQ_A),
        .DATA_A (DATA_A),
        .REQ_B  (REQ_B),
        .DATA_B (DATA_B),
        .GNT_A  (GNT_A),
        .GNT_B  (GNT_B),
        .D1     (D1),
        .D2     (D2),
        .D3     (D3),
        .D4     (D4),
        .BUSY   (BUSY)
    );

    always #12.5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Grant pair, busy and the full digit word in one go.
    task automatic chk_out(input string tag, input logic ga, input logic gb, input logic [15:0] word);
        chk({tag, ".gnt_a"}, {15'd0, GNT_A}, {15'd0, ga});
        chk({tag, ".gnt_b"}, {15'd0, GNT_B}, {15'd0, gb});
        chk({tag, ".busy"},  {15'd0, BUSY},  {15'd0, ga | gb});
        chk({tag, ".digits"}, {D4, D3, D2, D1}, word);
    endtask

    function automatic logic [15:0] idle_word(input logic [15:0] held);
`ifdef SEG7_ARB_IDLE_CLR_EN
        return 16'h0000;
`else
        return held;
`endif
    endfunction

    initial begin
        // Reset held with both requests asserted
        IN_CLR = 1'b0;
        REQ_A  = 1'b1;
        REQ_B  = 1'b1;
        DATA_A = 16'h5AF1;
        DATA_B = 16'hBEEF;
        tick();
        tick();
        chk_out("reset", 1'b0, 1'b0, 16'h0000);

        // Release: tie resolved to A because last resets to B (edge n)
        IN_CLR = 1'b1;
        tick();
        chk_out("first_grant", 1'b1, 1'b0, 16'h5AF1);
        chk("d1", {12'd0, D1}, 16'h0001);
        chk("d2", {12'd0, D2}, 16'h000F);
        chk("d3", {12'd0, D3}, 16'h000A);
        chk("d4", {12'd0, D4}, 16'h0005);

        // Live data: one cycle latency (edge n+1)
        DATA_A = 16'h1234;
        tick();
        chk_out("live_data", 1'b1, 1'b0, 16'h1234);

        // Edges n+2, n+3: A still holds while B waits
        tick();
        tick();
        chk_out("dwell_hold", 1'b1, 1'b0, 16'h1234);

        // Edge n+4: preempt, B gets the display with its data on the same edge
        tick();
        chk_out("preempt", 1'b0, 1'b1, 16'hBEEF);

        // Drop both: back to idle
        REQ_A = 1'b0;
        REQ_B = 1'b0;
        tick();
        chk_out("idle_after_b", 1'b0, 1'b0, idle_word(16'hBEEF));

        // Tie-break: last served was B, so A wins
        REQ_A = 1'b1;
        REQ_B = 1'b1;
        tick();
        chk_out("tie_a", 1'b1, 1'b0, 16'h1234);
        REQ_A = 1'b0;
        REQ_B = 1'b0;
        tick();
        chk_out("idle_after_tie_a", 1'b0, 1'b0, idle_word(16'h1234));
        // Next tie goes to B
        REQ_A = 1'b1;
        REQ_B = 1'b1;
        tick();
        chk_out("tie_b", 1'b0, 1'b1, 16'hBEEF);
        REQ_A = 1'b0;
        REQ_B = 1'b0;
        tick();
        chk_out("idle_after_tie_b", 1'b0, 1'b0, idle_word(16'hBEEF));

        // Single requester, early release at cycle 1
        DATA_A = 16'h5AF1;
        REQ_A  = 1'b1;
        tick();
        chk_out("single_a", 1'b1, 1'b0, 16'h5AF1);
        tick();
        REQ_A = 1'b0;
        tick();
        chk_out("early_release", 1'b0, 1'b0, idle_word(16'h5AF1));

        // Holder drop and other request rise on the same edge: direct switch
        REQ_A = 1'b1;
        tick();
        chk_out("regrant_a", 1'b1, 1'b0, 16'h5AF1);
        REQ_A = 1'b0;
        REQ_B = 1'b1;
        tick();
        chk_out("drop_switch", 1'b0, 1'b1, 16'hBEEF);

        // Counter reaches 2 in SHOW_B, then asynchronous reset mid-cycle
        tick();
        tick();
        chk_out("b_count2", 1'b0, 1'b1, 16'hBEEF);
        IN_CLR = 1'b0;
        #2;
        chk_out("async_reset", 1'b0, 1'b0, 16'h0000);
        tick();
        IN_CLR = 1'b1;

        // Re-request B: dwell must start from 0, so B holds for 4 edges
        tick();
        chk_out("rereq_b", 1'b0, 1'b1, 16'hBEEF);
        REQ_A = 1'b1;
        tick();
        tick();
        tick();
        chk_out("rereq_hold", 1'b0, 1'b1, 16'hBEEF);
        tick();
        chk_out("rereq_preempt", 1'b1, 1'b0, 16'h5AF1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_arb.md
# seg7_arb

Two-requester arbiter that shares the 4-digit seven-segment display between independent data sources. It sits directly upstream of the `segment7` driver. It owns `D1`..`D4`, grants the display to one requester at a time under round-robin with a minimum dwell time, and streams the granted requester's 16-bit value to the digits.

## Interface
- `DWELL`, default 40_000_000: minimum cycles a granted requester keeps the display while the other is waiting. 1 s at 40 MHz. Legal range ≥ 2.
- `CLK`  in  1  system clock, 40 MHz (25 ns period).
- `IN_CLR`  in  1  one clock; reset is asynchronous and active-low.
- `REQ_A`  in  1  requester A wants the display (level).
- `DATA_A`  in  16  requester A value; `[3:0]`→D1 … `[15:12]`→D4.
- `REQ_B`  in  1  requester B wants the display (level).
- `DATA_B`  in  16  requester B value, same mapping.
- `GNT_A`  out  1  A currently owns the display.
- `GNT_B`  out  1  B currently owns the display.
- `D1`, `D2`, `D3`, `D4`  out  4 each  digit codes to `segment7`.
- `BUSY`  out  1  `GNT_A | GNT_B`.

## Operation
- States: IDLE, SHOW_A, SHOW_B. Reset state is IDLE.
- `last` flag records the last served requester. Its reset value is B, so A wins the first tie.
- IDLE:
  - only `REQ_A` → SHOW_A.
  - only `REQ_B` → SHOW_B.
  - both → the requester ≠ `last`.
  - neither → stay in IDLE.
- SHOW_x:
  - `REQ_x` low → go to SHOW_y if `REQ_y` is high, else IDLE. This applies regardless of the dwell count.
  - `REQ_x` high, `REQ_y` high, dwell count == DWELL−1 → SHOW_y (preempt).
  - otherwise stay, and the dwell counter increments, saturating at DWELL−1.
- Dwell counter:
  - width `$clog2(DWELL)`.
  - cleared to 0 on every grant change, including entry from IDLE.
  - never wraps.
- `last` updates to x on entry to SHOW_x.
- Data path:
  - while in SHOW_x, D1..D4 register `DATA_x` every cycle, so the display shows a live value.
  - in IDLE, D1..D4 hold their last value (see Configuration).
- `GNT_A` and `GNT_B` are never high together. A direct switch A↔B has no idle gap.

## Timing
- Reset values: `GNT_A`=0, `GNT_B`=0, `BUSY`=0, D1..D4=4'h0, dwell counter=0, `last`=B.
- `IN_CLR` low mid-operation forces all reset values immediately, asynchronously. Operation resumes at the first rising edge after release.
- Grant latency: `REQ_x` sampled high at edge n (display free) → `GNT_x`=1 and D = `DATA_x` after edge n.
- Data latency: one cycle from `DATA_x` change to D1..D4 while granted.
- Release: `REQ_x` sampled low at edge n → `GNT_x`=0 after edge n. On that same edge, D takes `DATA_y` if y is granted.
- Preempt: the counter reaches DWELL−1 at edge m. With both requests high at edge m+1, the grant switches at edge m+1. The holder therefore keeps the display for exactly DWELL cycles.
- Simultaneous events, decided as follows:
  - Holder drop and other-request rise on the same edge → switch on that edge.
  - Both requests rising in IDLE → resolved by `last`.

## Configuration
- `SEG7_ARB_IDLE_CLR_EN` defined: on every transition into IDLE, D1..D4 load 4'h0 on the same edge that drops the grant.
- Undefined: D1..D4 retain the last granted value through IDLE.
- Grant and state behaviour are identical in both builds.

## Structure
- Package `seg7_pkg`:
  - state typedef (IDLE/SHOW_A/SHOW_B).
  - `digit_t` (4-bit), `word_t` (16-bit).
  - requester-id typedef used for `last`.
- Sub-module `seg7_dwell_timer`:
  - saturating counter with clear, parameter DWELL.
  - output `expired` when count == DWELL−1.
- The top contains the FSM and the digit registers.

## Test plan
All cases use DWELL=4.
- Reset: `IN_CLR`=0 with both requests high → GNT_A=GNT_B=0, D1..D4=0. Release → first edge grants A, since `last`=B.
- Single requester: REQ_A=1, DATA_A=16'h5AF1 → next edge GNT_A=1, D1=1, D2=F, D3=A, D4=5. Change DATA_A to 16'h1234 → D updates one cycle later.
- Preemption: A granted, REQ_B raised after 1 cycle → GNT_B rises exactly 4 cycles after GNT_A rose. D shows DATA_B on that same edge, and GNT_A falls on the same edge.
- Early release: A granted, drop REQ_A at cycle 1 with REQ_B=0 → next edge IDLE, BUSY=0. D1..D4=0 with `SEG7_ARB_IDLE_CLR_EN`, else hold 16'h5AF1.
- Tie-break: after serving B, return to IDLE, then raise both on the same edge → A granted. After the next return to IDLE, raise both again → B granted.
- Reset mid-grant: assert `IN_CLR`=0 while SHOW_B with counter=2 → outputs reset asynchronously before the next edge. After release, a re-request starts the dwell from 0.
